// File: rtl/smi_pkg.sv
// Shared constants and helpers for the SMI pin-side front end.
package smi_pkg;

    localparam int unsigned         SMI_DW             = 18;
    localparam logic                SMI_STROBE_IDLE    = 1'b1;
    localparam logic [SMI_DW-1:0]   SMI_UNDERFLOW_FILL = 18'h0;
    localparam int unsigned         SMI_SYNC_STAGES    = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/smi_sfifo.sv
// Synchronous FIFO, depth 2**LGFIFO, wrap-bit pointers; push while full only lands with a pop.
module smi_sfifo #(
    parameter int unsigned DW     = 18,
    parameter int unsigned LGFIFO = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_data
);

    localparam int unsigned DEPTH = 1 << LGFIFO;

    logic [DW-1:0]   mem [DEPTH];
    logic [LGFIFO:0] wr_ptr;
    logic [LGFIFO:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        o_empty = (wr_ptr == rd_ptr);
        o_full  = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                  (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
        do_pop  = i_pop & ~o_empty;
        do_push = i_push & (~o_full | do_pop);
        o_data  = mem[rd_ptr[LGFIFO-1:0]];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[LGFIFO-1:0]] <= i_data;
    end

endmodule

// File: rtl/smi_bus_frontend.sv
// SMI pin-side front end: strobe sync/edge detect, write-capture FIFO, read serving.
// Optional SMI_FRONTEND_COUNTERS_EN adds saturating overflow/underflow event counters.
module smi_bus_frontend
    import smi_pkg::*;
#(
    parameter int unsigned DW          = SMI_DW,
    parameter int unsigned SYNC_STAGES = SMI_SYNC_STAGES,
    parameter int unsigned LGFIFO      = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_smi_wen,
    input  logic          i_smi_oen,
    input  logic [DW-1:0] i_smi_data,
    output logic [DW-1:0] o_smi_data,
    output logic          o_smi_oen,
    output logic          M_WR_VALID,
    input  logic          M_WR_READY,
    output logic [DW-1:0] M_WR_DATA,
    input  logic          S_RD_VALID,
    output logic          S_RD_READY,
    input  logic [DW-1:0] S_RD_DATA,
    output logic          o_overflow,
    output logic          o_underflow
`ifdef SMI_FRONTEND_COUNTERS_EN
    ,
    output logic [7:0]    o_overflow_count,
    output logic [7:0]    o_underflow_count
`endif
);

    logic [SYNC_STAGES-1:0] wen_sync;
    logic [SYNC_STAGES-1:0] oen_sync;
    logic [DW-1:0]          data_sync [SYNC_STAGES+1];
    logic [SYNC_STAGES:0]   flush_sr;
    logic                   sync_ok;
    logic                   wen_s, oen_s, wen_prev, oen_prev;
    logic                   wen_fall, wen_rise, oen_fall, oen_rise;
    logic                   wr_armed, fall_d;
    logic [DW-1:0]          wr_word, data_s, push_data;
    logic                   wr_push, wr_pop, fifo_full, fifo_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wen_sync <= {SYNC_STAGES{SMI_STROBE_IDLE}};
            oen_sync <= {SYNC_STAGES{SMI_STROBE_IDLE}};
            wen_prev <= SMI_STROBE_IDLE;
            oen_prev <= SMI_STROBE_IDLE;
            flush_sr <= '0;
            for (int unsigned i = 0; i <= SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            wen_sync <= {wen_sync[SYNC_STAGES-2:0], i_smi_wen};
            oen_sync <= {oen_sync[SYNC_STAGES-2:0], i_smi_oen};
            wen_prev <= wen_s;
            oen_prev <= oen_s;
            flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
            data_sync[0] <= i_smi_data;
            for (int unsigned i = 1; i <= SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    // Edges are suppressed until the chains have flushed the reset idle value,
    // so a strobe already low at reset release never looks like a fresh fall.
    always_comb begin
        wen_s    = wen_sync[SYNC_STAGES-1];
        oen_s    = oen_sync[SYNC_STAGES-1];
        data_s   = data_sync[SYNC_STAGES];
        sync_ok  = flush_sr[SYNC_STAGES];
        wen_fall = sync_ok &  wen_prev & ~wen_s;
        wen_rise = sync_ok & ~wen_prev &  wen_s;
        oen_fall = sync_ok &  oen_prev & ~oen_s;
        oen_rise = sync_ok & ~oen_prev &  oen_s;
    end

    // A one-cycle strobe rises while the capture is still in flight; forward it.
    always_comb begin
        push_data  = fall_d ? data_s : wr_word;
        wr_push    = wen_rise & wr_armed;
        wr_pop     = M_WR_VALID & M_WR_READY;
        M_WR_VALID = ~fifo_empty;
        S_RD_READY = oen_fall;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_armed    <= 1'b0;
            fall_d      <= 1'b0;
            wr_word     <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_smi_oen   <= 1'b1;
            o_smi_data  <= '0;
        end else begin
            fall_d      <= wen_fall;
            if (wen_fall)      wr_armed <= 1'b1;
            else if (wen_rise) wr_armed <= 1'b0;
            if (fall_d) wr_word <= data_s;
            o_overflow  <= wr_push & fifo_full & ~wr_pop;
            o_underflow <= oen_fall & ~S_RD_VALID;
            if (oen_fall) begin
                o_smi_oen  <= 1'b0;
                o_smi_data <= S_RD_VALID ? S_RD_DATA : DW'(SMI_UNDERFLOW_FILL);
            end else if (oen_rise) begin
                o_smi_oen  <= 1'b1;
            end
        end
    end

    smi_sfifo #(
        .DW     (DW),
        .LGFIFO (LGFIFO)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (wr_push),
        .i_data  (push_data),
        .i_pop   (wr_pop),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_data  (M_WR_DATA)
    );

`ifdef SMI_FRONTEND_COUNTERS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow_count  <= '0;
            o_underflow_count <= '0;
        end else begin
            if (o_overflow)  o_overflow_count  <= sat_inc8(o_overflow_count);
            if (o_underflow) o_underflow_count <= sat_inc8(o_underflow_count);
        end
    end
`endif

endmodule

// File: tb/tb_smi_bus_frontend.sv
// Directed self-checking bench for smi_bus_frontend (default parameters, SYNC_STAGES = 2).
module tb_smi_bus_frontend;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_smi_wen = 1'b1;
    logic        i_smi_oen = 1'b1;
    logic [17:0] i_smi_data = '0;
    logic [17:0] o_smi_data;
    logic        o_smi_oen;
    logic        M_WR_VALID;
    logic        M_WR_READY = 1'b0;
    logic [17:0] M_WR_DATA;
    logic        S_RD_VALID = 1'b0;
    logic        S_RD_READY;
    logic [17:0] S_RD_DATA = '0;
    logic        o_overflow;
    logic        o_underflow;
`ifdef SMI_FRONTEND_COUNTERS_EN
    logic [7:0]  ovf_count;
    logic [7:0]  unf_count;
`endif

    int errors = 0;
    int checks = 0;
    int ovf_pulses = 0;
    int unf_pulses = 0;
    int rdy_pulses = 0;

    always #5 i_clk = ~i_clk;

    smi_bus_frontend dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_smi_wen   (i_smi_wen),
        .i_smi_oen   (i_smi_oen),
        .i_smi_data  (i_smi_data),
        .o_smi_data  (o_smi_data),
        .o_smi_oen   (o_smi_oen),
        .M_WR_VALID  (M_WR_VALID),
        .M_WR_READY  (M_WR_READY),
        .M_WR_DATA   (M_WR_DATA),
        .S_RD_VALID  (S_RD_VALID),
        .S_RD_READY  (S_RD_READY),
        .S_RD_DATA   (S_RD_DATA),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`ifdef SMI_FRONTEND_COUNTERS_EN
        ,
        .o_overflow_count  (ovf_count),
        .o_underflow_count (unf_count)
`endif
    );

    always @(negedge i_clk) begin
        if (o_overflow)  ovf_pulses++;
        if (o_underflow) unf_pulses++;
        if (S_RD_READY)  rdy_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Push lands on the third edge after wen is raised.
    task automatic do_write(input logic [17:0] d, input int low, input bit pop_at_push);
        i_smi_data = d;
        i_smi_wen  = 1'b0;
        tick(low);
        i_smi_wen  = 1'b1;
        tick(2);
        if (pop_at_push) M_WR_READY = 1'b1;
        tick(1);
        M_WR_READY = 1'b0;
    endtask

    task automatic drain_check(input int first, input int n, input string tag);
        M_WR_READY = 1'b1;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (M_WR_VALID !== 1'b1 || M_WR_DATA !== 18'(first + k)) begin
                errors++;
                $display("FAIL %s word %0d: valid=%b data=%h, need valid=1 data=%h",
                         tag, k, M_WR_VALID, M_WR_DATA, 18'(first + k));
            end
            tick(1);
        end
        M_WR_READY = 1'b0;
        checks++;
        if (M_WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL %s empty-after-drain: valid=%b, need 0", tag, M_WR_VALID);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_smi_oen, o_smi_data, M_WR_VALID, S_RD_READY, o_overflow, o_underflow}
            !== {1'b1, 18'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: oen=%b data=%h wv=%b rr=%b ovf=%b unf=%b, need 1 0 0 0 0 0",
                     o_smi_oen, o_smi_data, M_WR_VALID, S_RD_READY, o_overflow, o_underflow);
        end
`ifdef SMI_FRONTEND_COUNTERS_EN
        checks++;
        if (ovf_count !== 8'd0 || unf_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: ovf=%0d unf=%0d, need 0 0", ovf_count, unf_count);
        end
`endif
    endtask

    task automatic test_single_write();
        i_smi_data = 18'h1A5A5;
        i_smi_wen  = 1'b0;
        tick(10);
        i_smi_wen  = 1'b1;
        tick(2);
        checks++;
        if (M_WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_write early valid: got %b, need 0", M_WR_VALID);
        end
        tick(1);
        checks++;
        if (M_WR_VALID !== 1'b1 || M_WR_DATA !== 18'h1A5A5) begin
            errors++;
            $display("FAIL single_write word: valid=%b data=%h, need 1 1a5a5", M_WR_VALID, M_WR_DATA);
        end
        M_WR_READY = 1'b1;
        tick(1);
        M_WR_READY = 1'b0;
        checks++;
        if (M_WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_write pop: valid=%b, need 0", M_WR_VALID);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = ovf_pulses;
        for (int i = 0; i < 17; i++) begin
            do_write(18'(i), 4, 1'b0);
            tick(1);
            if (i == 15) begin
                checks++;
                if (ovf_pulses - base !== 0) begin
                    errors++;
                    $display("FAIL overflow early: pulses=%0d after 16 writes, need 0", ovf_pulses - base);
                end
            end
        end
        checks++;
        if (ovf_pulses - base !== 1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow pulse: pulses=%0d level=%b, need 1 0", ovf_pulses - base, o_overflow);
        end
`ifdef SMI_FRONTEND_COUNTERS_EN
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL overflow_count: got %0d, need 1", ovf_count);
        end
`endif
        drain_check(0, 16, "overflow_drain");
    endtask

    task automatic test_read();
        int rb, ub;
        rb = rdy_pulses;
        ub = unf_pulses;
        S_RD_VALID = 1'b1;
        S_RD_DATA  = 18'h3FFFF;
        i_smi_oen  = 1'b0;
        tick(2);
        checks++;
        if (S_RD_READY !== 1'b1 || o_smi_oen !== 1'b1) begin
            errors++;
            $display("FAIL read_hit fall cycle: ready=%b oen=%b, need 1 1", S_RD_READY, o_smi_oen);
        end
        tick(1);
        checks++;
        if (S_RD_READY !== 1'b0 || o_smi_oen !== 1'b0 || o_smi_data !== 18'h3FFFF) begin
            errors++;
            $display("FAIL read_hit drive: ready=%b oen=%b data=%h, need 0 0 3ffff",
                     S_RD_READY, o_smi_oen, o_smi_data);
        end
        S_RD_VALID = 1'b0;
        tick(5);
        i_smi_oen = 1'b1;
        tick(3);
        checks++;
        if (o_smi_oen !== 1'b1 || o_smi_data !== 18'h3FFFF) begin
            errors++;
            $display("FAIL read_hit release: oen=%b data=%h, need 1 3ffff", o_smi_oen, o_smi_data);
        end
        tick(1);
        checks++;
        if (rdy_pulses - rb !== 1 || unf_pulses - ub !== 0) begin
            errors++;
            $display("FAIL read_hit pulses: ready=%0d underflow=%0d, need 1 0", rdy_pulses - rb, unf_pulses - ub);
        end

        S_RD_VALID = 1'b0;
        S_RD_DATA  = 18'h3FFFF;
        i_smi_oen  = 1'b0;
        tick(3);
        checks++;
        if (o_smi_oen !== 1'b0 || o_smi_data !== 18'h0 || o_underflow !== 1'b1) begin
            errors++;
            $display("FAIL read_underflow: oen=%b data=%h unf=%b, need 0 00000 1",
                     o_smi_oen, o_smi_data, o_underflow);
        end
        tick(5);
        i_smi_oen = 1'b1;
        tick(4);
        checks++;
        if (rdy_pulses - rb !== 2 || unf_pulses - ub !== 1 || o_smi_oen !== 1'b1) begin
            errors++;
            $display("FAIL read_underflow pulses: ready=%0d underflow=%0d oen=%b, need 2 1 1",
                     rdy_pulses - rb, unf_pulses - ub, o_smi_oen);
        end
`ifdef SMI_FRONTEND_COUNTERS_EN
        checks++;
        if (unf_count !== 8'd1) begin
            errors++;
            $display("FAIL underflow_count: got %0d, need 1", unf_count);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        i_smi_data = 18'h0BEEF;
        i_smi_wen  = 1'b0;
        tick(5);
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_smi_oen !== 1'b1 || M_WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid in reset: oen=%b valid=%b, need 1 0", o_smi_oen, M_WR_VALID);
        end
        tick(2);
        i_reset = 1'b0;
        tick(5);
        i_smi_wen = 1'b1;
        tick(6);
        checks++;
        if (M_WR_VALID !== 1'b0 || o_smi_oen !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid after release: valid=%b oen=%b, need 0 1", M_WR_VALID, o_smi_oen);
        end
    endtask

    task automatic test_full_concurrent();
        int base;
        base = ovf_pulses;
        for (int i = 0; i < 16; i++) do_write(18'(100 + i), 3, 1'b0);
        do_write(18'd116, 3, 1'b1);
        tick(2);
        checks++;
        if (ovf_pulses - base !== 0) begin
            errors++;
            $display("FAIL full_concurrent overflow: pulses=%0d, need 0", ovf_pulses - base);
        end
        drain_check(101, 16, "full_concurrent_drain");
    endtask

    task automatic test_glitch();
        i_smi_data = 18'h2AAAA;
        i_smi_wen  = 1'b0;
        tick(1);
        i_smi_wen  = 1'b1;
        i_smi_data = 18'h15555;
        tick(6);
        checks++;
        if (M_WR_VALID !== 1'b1 || M_WR_DATA !== 18'h2AAAA) begin
            errors++;
            $display("FAIL glitch word: valid=%b data=%h, need 1 2aaaa", M_WR_VALID, M_WR_DATA);
        end
        M_WR_READY = 1'b1;
        tick(1);
        M_WR_READY = 1'b0;
        checks++;
        if (M_WR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL glitch second push: valid=%b, need 0", M_WR_VALID);
        end
    endtask

    initial begin
        tick(3);
        test_reset();
        i_reset = 1'b0;
        tick(5);
        test_single_write();
        tick(3);
        test_overflow();
        tick(3);
        test_read();
        tick(3);
        test_reset_mid_write();
        tick(3);
        test_full_concurrent();
        tick(3);
        test_glitch();
`ifdef SMI_FRONTEND_COUNTERS_EN
        checks++;
        if (ovf_count !== 8'd1 || unf_count !== 8'd1) begin
            errors++;
            $display("FAIL final_counters: ovf=%0d unf=%0d, need 1 1", ovf_count, unf_count);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
